pll_lock_sequencer: RTL and testbench

Power-up and recovery sequencer for the PLL that produces the LED PWM clock (50 MHz reference in, single enabled output). It runs on the free-running reference clock and drives the PLL's active-high reset. It waits for the lock signal with a timeout, qualifies lock as stable, retries a bounded number of times, and reports ready/fault. It also restarts the PLL on loss of lock or on a software restart request.

---
 rtl/pll_lock_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: holds the PLL in reset, waits for a qualified
// lock with a bounded timeout and retry budget, and restarts on loss of lock.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 50,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       pll_ready,
  output logic       fault,
  output logic [2:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [STB_W-1:0] STB_MAX   = STB_W'(LOCK_STABLE);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_STAB  = 3'd2,
    ST_READY = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_reset_q, pll_ready_q, fault_q;

  logic [TMO_W-1:0] tmo_inc;
  logic [STB_W-1:0] stb_inc;
  logic [2:0]       retry_inc;
  logic             timed_out;

  // pll_lock comes from the PLL's own clock domain; only lock_s_q is used below.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      tmo_q       <= '0;
      stb_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      pll_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      stb_q       <= stb_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == ST_RST) || (state_d == ST_FAULT);
      pll_ready_q <= (state_d == ST_READY);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  // tmo and stb stop at their terminal values instead of wrapping.
  assign tmo_inc   = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TMO_W'(1);
  assign stb_inc   = (stb_q == STB_MAX) ? stb_q : stb_q + STB_W'(1);
  assign retry_inc = retry_q + 3'd1;
  assign timed_out = (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart) begin
      state_d = ST_RST;
      cnt_d   = '0;
      tmo_d   = '0;
      stb_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            tmo_d   = '0;
            stb_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT: begin
          tmo_d = tmo_inc;
          if (lock_s_q) begin
            state_d = ST_STAB;
            stb_d   = STB_W'(1);
          end else if (timed_out) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RST;
          end
        end

        // The timeout window spans WAIT and STAB, so tmo is never cleared here.
        ST_STAB: begin
          tmo_d = tmo_inc;
          if (lock_s_q && (stb_q >= STB_LAST)) begin
            state_d = ST_READY;
            stb_d   = stb_inc;
            retry_d = '0;
          end else if (timed_out) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RST;
          end else if (!lock_s_q) begin
            state_d = ST_WAIT;
            stb_d   = '0;
          end else begin
            stb_d = stb_inc;
          end
        end

        ST_READY: begin
          if (!lock_s_q) begin
            state_d = ST_RST;
            cnt_d   = '0;
            retry_d = '0;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end

        ST_FAULT: state_d = ST_FAULT;

        default: begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pll_reset = pll_reset_q;
  assign pll_ready = pll_ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2).
module tb_pll_lock_sequencer;

  logic       clkin    = 1'b0;
  logic       rst_n    = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       pll_reset;
  logic       pll_ready;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  pll_lock_sequencer #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .MAX_RETRY   (2)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .pll_ready(pll_ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // checking
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // sel: 0 = pll_reset, 1 = pll_ready, 2 = state_dbg. n = edges taken, -1 if never seen.
  task automatic ticks_until(input int sel, input int val, output int n);
    int v;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      v = (sel == 0) ? int'(pll_reset) : (sel == 1) ? int'(pll_ready) : int'(state_dbg);
      if (v == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    int n;

    // reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    check("rst_pll_reset", pll_reset, 1);
    check("rst_pll_ready", pll_ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;

    // 1: nominal lock
    ticks_until(0, 0, n);
    check("s1_rst_len", n, 4);
    check("s1_state_wait", state_dbg, 1);
    repeat (6) tick();
    pll_lock = 1'b1;
    ticks_until(1, 1, n);
    check("s1_ready_latency", n, 10);
    check("s1_retry", retry_cnt, 0);
    check("s1_fault", fault, 0);
    check("s1_pll_reset", pll_reset, 0);
    check("s1_state_ready", state_dbg, 3);

    // 4: loss of lock, repeated until loss_cnt saturates
    for (int i = 1; i <= 300; i++) begin
      pll_lock = 1'b0;
      ticks_until(1, 0, n);
      check("s4_drop_latency", n, 3);
      check("s4_reset_same_edge", pll_reset, 1);
      check("s4_loss_cnt", loss_cnt, (i > 255) ? 255 : i);
      pll_lock = 1'b1;
      ticks_until(1, 1, n);
      check("s4_relock_latency", n, 12);
    end
    check("s4_loss_sat", loss_cnt, 255);

    // asynchronous reset out of READY
    pll_lock = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ar_ready_async", pll_ready, 0);
    check("ar_reset_async", pll_reset, 1);
    check("ar_loss_cleared", loss_cnt, 0);
    @(posedge clkin);
    #1;
    rst_n = 1'b1;

    // 2: timeout, retry, fault, restart
    ticks_until(0, 0, n);
    check("s2_rst_len1", n, 4);
    ticks_until(0, 1, n);
    check("s2_wait_len1", n, 20);
    check("s2_retry1", retry_cnt, 1);
    check("s2_state_rst", state_dbg, 0);
    check("s2_fault_low", fault, 0);
    ticks_until(0, 0, n);
    check("s2_rst_len2", n, 4);
    ticks_until(0, 1, n);
    check("s2_wait_len2", n, 20);
    check("s2_retry2", retry_cnt, 2);
    check("s2_fault", fault, 1);
    check("s2_state_fault", state_dbg, 4);
    repeat (5) tick();
    check("s2_fault_sticky", fault, 1);
    check("s2_reset_held", pll_reset, 1);
    check("s2_state_sticky", state_dbg, 4);
    pulse_restart();
    check("s2_rs_fault", fault, 0);
    check("s2_rs_retry", retry_cnt, 0);
    check("s2_rs_state", state_dbg, 0);
    check("s2_rs_reset", pll_reset, 1);
    ticks_until(0, 0, n);
    check("s2_rs_rst_len", n, 4);

    // 3: one-cycle glitch during STAB restarts the stable count
    exp_q = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1,
              3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    pll_lock = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) pll_lock = 1'b0;
      if (k == 6) pll_lock = 1'b1;
      check($sformatf("s3_state_%0d", k), state_dbg, exp_q.pop_front());
    end
    check("s3_ready", pll_ready, 1);
    check("s3_retry", retry_cnt, 0);

    // 5a: restart wins over a timeout in the same cycle
    pll_lock = 1'b0;
    ticks_until(1, 0, n);
    check("s5_drop_latency", n, 3);
    check("s5_loss", loss_cnt, 1);
    ticks_until(0, 0, n);
    check("s5_rst_len", n, 4);
    repeat (19) tick();
    check("s5_pre_timeout_state", state_dbg, 1);
    pulse_restart();
    check("s5_rs_state", state_dbg, 0);
    check("s5_rs_retry", retry_cnt, 0);
    check("s5_rs_fault", fault, 0);
    check("s5_rs_reset", pll_reset, 1);
    check("s5_rs_loss_kept", loss_cnt, 1);
    ticks_until(0, 0, n);
    check("s5_rst_len2", n, 4);
    ticks_until(0, 1, n);
    check("s5_wait_len", n, 20);
    check("s5_retry_after", retry_cnt, 1);
    check("s5_no_fault", fault, 0);

    // 5b: asynchronous reset while in STAB
    pll_lock = 1'b1;
    ticks_until(2, 2, n);
    check("s5_reach_stab", n, 5);
    #2 rst_n = 1'b0;
    #1;
    check("s5_ar_reset", pll_reset, 1);
    check("s5_ar_ready", pll_ready, 0);
    check("s5_ar_state", state_dbg, 0);
    check("s5_ar_retry", retry_cnt, 0);
    @(posedge clkin);
    #1;
    rst_n = 1'b1;
    ticks_until(0, 0, n);
    check("s5_post_rst_len", n, 4);
    ticks_until(1, 1, n);
    check("s5_post_ready", n, 8);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
